// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALU definitions: opcode constants and data width, used by the
// existing ALU and by the multiply sequencer.
package alu_mul_sequencer_pkg;

  localparam int unsigned ALU_W = 32;

  localparam logic [2:0] ALU_OP_ADD = 3'b000;
  localparam logic [2:0] ALU_OP_SUB = 3'b001;
  localparam logic [2:0] ALU_OP_LSR = 3'b010;  // left shift
  localparam logic [2:0] ALU_OP_RSR = 3'b011;  // right shift

  typedef logic [ALU_W-1:0] word_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand/product handshake bundle for the multiply sequencer.
interface alu_mul_sequencer_if;
  import alu_mul_sequencer_pkg::*;

  logic  in_valid;
  logic  in_ready;
  word_t a;
  word_t b;
  logic  out_valid;
  logic  out_ready;
  word_t product;
  logic  busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/alu_mul_sequencer_alu.sv
// Shared combinational ALU: add, subtract, left shift, right shift.
module alu_mul_sequencer_alu
  import alu_mul_sequencer_pkg::*;
(
  input  logic [2:0] i_op,
  input  word_t      i_in0,
  input  word_t      i_in1,
  output word_t      o_out
);

  // Pure combinational operation select; unknown opcodes yield zero.
  always_comb begin
    o_out = '0;
    case (i_op)
      ALU_OP_ADD: o_out = i_in0 + i_in1;
      ALU_OP_SUB: o_out = i_in0 - i_in1;
      ALU_OP_LSR: o_out = i_in0 << i_in1;
      ALU_OP_RSR: o_out = i_in0 >> i_in1;
      default:    o_out = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32-bit unsigned multiplier that sequences the shared ALU
// across cycles (ADD for accumulate, LSR for multiplicand doubling).
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  alu_mul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t     r_state;
  word_t      r_acc;
  word_t      r_mcand;
  word_t      r_mplier;
  logic [5:0] r_cnt;
  logic       r_in_ready;
  logic       r_out_valid;
  word_t      r_product;
  logic       r_busy;

  logic [2:0] w_alu_op;
  word_t      w_alu_in0;
  word_t      w_alu_in1;
  word_t      w_alu_out;
  logic       w_done_cond;

  assign w_done_cond = EARLY_EXIT ? (r_mplier == '0) : (r_cnt == 6'd32);

  // ALU operand/op mux: doubling of mcand in SHIFT, accumulate otherwise.
  always_comb begin
    w_alu_op  = ALU_OP_ADD;
    w_alu_in0 = r_acc;
    w_alu_in1 = r_mcand;
    if (r_state == S_SHIFT) begin
      w_alu_op  = ALU_OP_LSR;
      w_alu_in0 = r_mcand;
      w_alu_in1 = 32'd1;
    end
  end

  alu_mul_sequencer_alu u_alu (
    .i_op  (w_alu_op),
    .i_in0 (w_alu_in0),
    .i_in1 (w_alu_in1),
    .o_out (w_alu_out)
  );

  // Sequencer FSM; outputs are registered and updated on each transition.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_acc      <= '0;
            r_mcand    <= bus.a;
            r_mplier   <= bus.b;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (w_done_cond) begin
            r_out_valid <= 1'b1;
            r_product   <= r_acc;
            r_state     <= S_DONE;
          end else if (r_mplier[0]) begin
            r_state <= S_ADD;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_ADD: begin
          r_acc   <= w_alu_out;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_mcand  <= w_alu_out;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          r_state  <= S_EVAL;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one instance with early exit, one
// with fixed 32-iteration latency.
module tb_alu_mul_sequencer;

  logic clk;
  logic reset_n;
  int   passed;
  int   total;

  alu_mul_sequencer_if bus0 ();
  alu_mul_sequencer_if bus1 ();

  alu_mul_sequencer #(.EARLY_EXIT(1'b1)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  alu_mul_sequencer #(.EARLY_EXIT(1'b0)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic ordy);
    if (sel == 0) begin
      bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.out_ready = ordy;
    end else begin
      bus1.in_valid = v; bus1.a = a; bus1.b = b; bus1.out_ready = ordy;
    end
  endtask

  function automatic logic g_ov(input int sel);
    return (sel == 0) ? bus0.out_valid : bus1.out_valid;
  endfunction
  function automatic logic g_ir(input int sel);
    return (sel == 0) ? bus0.in_ready : bus1.in_ready;
  endfunction
  function automatic logic g_busy(input int sel);
    return (sel == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic [31:0] g_prod(input int sel);
    return (sel == 0) ? bus0.product : bus1.product;
  endfunction

  task automatic wait_done(input int sel, input int lat, input string nm);
    int n;
    n = 0;
    while (!g_ov(sel) && n < 400) begin
      step();
      n++;
    end
    chk({nm, " latency"}, n, lat);
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    chk({nm, " in_ready before"}, {31'd0, g_ir(sel)}, 32'd1);
    drive(sel, 1'b1, a, b, 1'b1);
    step();
    drive(sel, 1'b0, '0, '0, 1'b1);
    chk({nm, " busy"}, {31'd0, g_busy(sel)}, 32'd1);
    chk({nm, " in_ready busy"}, {31'd0, g_ir(sel)}, 32'd0);
    wait_done(sel, lat, nm);
    chk({nm, " product"}, g_prod(sel), exp);
    step();
    chk({nm, " out_valid after"}, {31'd0, g_ov(sel)}, 32'd0);
    chk({nm, " in_ready after"}, {31'd0, g_ir(sel)}, 32'd1);
    chk({nm, " product idle"}, g_prod(sel), 32'd0);
  endtask

  initial begin
    int ov_seen;
    passed = 0;
    total  = 0;

    vecs[0]  = '{0, 32'd2536,       32'd113,        32'd286568,     19};
    vecs[1]  = '{0, 32'd5,          32'd0,          32'd0,          1};
    vecs[2]  = '{0, 32'd7,          32'd1,          32'd7,          4};
    vecs[3]  = '{0, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFE,   6};
    vecs[4]  = '{0, 32'h00010000,   32'h00010000,   32'd0,          36};
    vecs[5]  = '{0, 32'd6,          32'd7,          32'd42,         10};
    vecs[6]  = '{0, 32'd3,          32'd3,          32'd9,          7};
    vecs[7]  = '{0, 32'd12345,      32'h80000000,   32'h80000000,   66};
    vecs[8]  = '{1, 32'd6,          32'd7,          32'd42,         68};
    vecs[9]  = '{1, 32'd5,          32'd0,          32'd0,          65};
    vecs[10] = '{1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          97};

    drive(0, 1'b0, '0, '0, 1'b1);
    drive(1, 1'b0, '0, '0, 1'b1);
    reset_n = 1'b0;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset in_ready dut%0d", s), {31'd0, g_ir(s)}, 32'd1);
      chk($sformatf("reset out_valid dut%0d", s), {31'd0, g_ov(s)}, 32'd0);
      chk($sformatf("reset product dut%0d", s), g_prod(s), 32'd0);
      chk($sformatf("reset busy dut%0d", s), {31'd0, g_busy(s)}, 32'd0);
    end
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Backpressure: DONE stalled, new operands offered throughout.
    drive(0, 1'b1, 32'd3, 32'd3, 1'b0);
    step();
    drive(0, 1'b1, 32'd100, 32'd200, 1'b0);
    wait_done(0, 7, "bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid held", {31'd0, g_ov(0)}, 32'd1);
      chk("bp product held", g_prod(0), 32'd9);
      chk("bp in_ready low", {31'd0, g_ir(0)}, 32'd0);
      step();
    end
    chk("bp still done", {31'd0, g_ov(0)}, 32'd1);
    drive(0, 1'b1, 32'd100, 32'd200, 1'b1);
    step();
    chk("bp idle in_ready", {31'd0, g_ir(0)}, 32'd1);
    chk("bp idle out_valid", {31'd0, g_ov(0)}, 32'd0);
    step();
    drive(0, 1'b0, '0, '0, 1'b1);
    chk("bp new accepted busy", {31'd0, g_busy(0)}, 32'd1);
    wait_done(0, 20, "bp2");
    chk("bp2 product", g_prod(0), 32'd20000);
    step();

    // Reset in the middle of an operation.
    drive(0, 1'b1, 32'd2536, 32'd113, 1'b1);
    step();
    drive(0, 1'b0, '0, '0, 1'b1);
    ov_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (g_ov(0)) ov_seen++;
      step();
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst out_valid never", ov_seen, 32'd0);
    chk("midrst in_ready", {31'd0, g_ir(0)}, 32'd1);
    chk("midrst busy", {31'd0, g_busy(0)}, 32'd0);
    chk("midrst out_valid", {31'd0, g_ov(0)}, 32'd0);
    chk("midrst product", g_prod(0), 32'd0);
    step();
    run_op(0, 32'd6, 32'd7, 32'd42, 10, "postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
